uart_rx_frame: RTL and testbench

Parametrised UART receiver with oversampled, majority-voted bit recovery. Supports configurable data width, parity and stop bits, and reports framing, parity and overrun errors. Presents each received word on a valid/ready interface, so downstream logic (LCD command decoder, FIFO) can accept it at its own pace. Sits between the board RX pin and the character/command path of the design.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_os_tick.sv | 57 +++++
 rtl/uart_rx_frame.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and tick-divisor helper for the UART receiver.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // Clocks per oversample tick, floored, never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned d;
    d = clk_freq / (baud * os);
    return (d == 0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one tick every DIV clocks, with the tick's index inside the bit.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter  int unsigned DIV        = 1,
  parameter  int unsigned OVERSAMPLE = 16,
  localparam int unsigned IDX_W      = $clog2(OVERSAMPLE)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  output logic             o_tick,
  output logic [IDX_W-1:0] o_tick_idx
);

  localparam int unsigned      CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Divide the clock; the index advances after each tick and wraps per bit period.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    idx_d  = idx_q;
    if (tick_q) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    if (i_clr) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      idx_q  <= idx_d;
    end
  end

  assign o_tick     = tick_q;
  assign o_tick_idx = idx_q;

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampled UART receiver with 2-of-3 bit voting and a valid/ready word output.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  input  logic                 i_rx_ready,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int unsigned      DIV      = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned      IDX_W    = $clog2(OVERSAMPLE);
  localparam int unsigned      BIT_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] SMP0     = IDX_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] SMP1     = IDX_W'(OVERSAMPLE / 2);
  localparam logic [IDX_W-1:0] VOTE     = IDX_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic                 tick;
  logic [IDX_W-1:0]     tick_idx;
  logic                 clr_c, vote_c, bit_c, commit_c, par_bad_c, stop_last_c;
  logic [1:0]           smp_q, smp_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                 overrun_q, overrun_d, busy_q, busy_d;

  // Two-flop synchroniser for the asynchronous line; idles high out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], i_rx};
  end
  assign rx_s = sync_q[1];

  uart_os_tick #(
    .DIV        (DIV),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (clr_c),
    .o_tick     (tick),
    .o_tick_idx (tick_idx)
  );

  assign vote_c = tick && (tick_idx == VOTE);
  assign bit_c  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

  if (PARITY != PARITY_NONE) begin : g_par
    localparam logic ODD = (PARITY == PARITY_ODD);
    assign par_bad_c = ((^shift_q) ^ bit_c) != ODD;
  end else begin : g_nopar
    assign par_bad_c = 1'b0;
  end

  if (STOP_BITS == 2) begin : g_stop2
    logic stop_cnt_q, stop_cnt_d;
    // Count which stop bit is being voted; cleared outside STOP.
    always_comb begin
      stop_cnt_d = stop_cnt_q;
      if (state_q != ST_STOP) stop_cnt_d = 1'b0;
      else if (vote_c)        stop_cnt_d = ~stop_cnt_q;
    end
    // Stop-bit index register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) stop_cnt_q <= 1'b0;
      else          stop_cnt_q <= stop_cnt_d;
    end
    assign stop_last_c = stop_cnt_q;
  end else begin : g_stop1
    assign stop_last_c = 1'b1;
  end

  // Frame FSM, sample capture and word commit/handshake.
  always_comb begin
    state_d   = state_q;
    smp_d     = smp_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    armed_d   = armed_q;
    clr_c     = 1'b0;
    commit_c  = 1'b0;
    rx_data_d = rx_data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    overrun_d = 1'b0;

    if (tick && (tick_idx == SMP0)) smp_d[0] = rx_s;
    if (tick && (tick_idx == SMP1)) smp_d[1] = rx_s;

    case (state_q)
      ST_IDLE: begin
        clr_c = 1'b1;
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
        end
      end
      ST_START: if (vote_c) state_d = bit_c ? ST_IDLE : ST_DATA;
      ST_DATA: if (vote_c) begin
        shift_d   = {bit_c, shift_q[DATA_BITS-1:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (vote_c) begin
        if (par_bad_c) par_err_d = 1'b1;
        state_d = ST_STOP;
      end
      ST_STOP: if (vote_c) begin
        if (!bit_c) frm_err_d = 1'b1;
        if (stop_last_c) begin
          commit_c = 1'b1;
          armed_d  = bit_c;  // after a low stop (break) wait for the line to return high
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (valid_q && i_rx_ready) valid_d = 1'b0;
    if (commit_c) begin
      rx_data_d = shift_q;
      valid_d   = 1'b1;
      perr_d    = par_err_q;
      ferr_d    = frm_err_d;
      overrun_d = valid_q && !i_rx_ready;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      smp_q     <= 2'b11;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      armed_q   <= 1'b1;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      smp_q     <= smp_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      armed_q   <= armed_d;
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign o_rx_data    = rx_data_q;
  assign o_rx_valid   = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_overrun    = overrun_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: four configurations (8N1, 7E1, 8N2, 8O1) sharing clock and reset.
module tb_uart_rx_frame;

  localparam int unsigned TB_CLK = 614_400;  // with 9600 baud x16 -> DIV = 4
  localparam int unsigned BAUD   = 9600;
  localparam int          BIT    = 64;       // clocks per bit

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       flip;
    logic [1:0] stops;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic       clk, rst_n;
  logic       rx   [4];
  logic       rdy  [4];
  logic       val  [4];
  logic       perr [4];
  logic       ferr [4];
  logic       ovr  [4];
  logic       bsy  [4];
  logic [7:0] d0, d2, d3;
  logic [6:0] d1;

  int   n_checks, n_errs;
  exp_t exp_q[$];
  vec_t tbl[$];
  int   vrise[4], ovr_cnt[4], orun[4];
  int   omax;
  logic vprev[4];

  uart_rx_frame #(.CLK_FREQ(TB_CLK), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[0]), .i_rx_ready(rdy[0]),
    .o_rx_data(d0), .o_rx_valid(val[0]), .o_parity_err(perr[0]),
    .o_frame_err(ferr[0]), .o_overrun(ovr[0]), .o_busy(bsy[0]));

  uart_rx_frame #(.CLK_FREQ(TB_CLK), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
                  .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[1]), .i_rx_ready(rdy[1]),
    .o_rx_data(d1), .o_rx_valid(val[1]), .o_parity_err(perr[1]),
    .o_frame_err(ferr[1]), .o_overrun(ovr[1]), .o_busy(bsy[1]));

  uart_rx_frame #(.CLK_FREQ(TB_CLK), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[2]), .i_rx_ready(rdy[2]),
    .o_rx_data(d2), .o_rx_valid(val[2]), .o_parity_err(perr[2]),
    .o_frame_err(ferr[2]), .o_overrun(ovr[2]), .o_busy(bsy[2]));

  uart_rx_frame #(.CLK_FREQ(TB_CLK), .BAUD_RATE(BAUD), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[3]), .i_rx_ready(rdy[3]),
    .o_rx_data(d3), .o_rx_valid(val[3]), .o_parity_err(perr[3]),
    .o_frame_err(ferr[3]), .o_overrun(ovr[3]), .o_busy(bsy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] dut_data(input int k);
    case (k)
      0:       return {1'b0, d0};
      1:       return {2'b00, d1};
      2:       return {1'b0, d2};
      default: return {1'b0, d3};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame shape per instance: data bits, parity mode (0 none, 1 odd, 2 even), stop bits.
  task automatic cfg(input int k, output int nd, output int pm, output int ns);
    case (k)
      0:       begin nd = 8; pm = 0; ns = 1; end
      1:       begin nd = 7; pm = 2; ns = 1; end
      2:       begin nd = 8; pm = 0; ns = 2; end
      default: begin nd = 8; pm = 1; ns = 1; end
    endcase
  endtask

  task automatic build(input int k, input logic [8:0] d, input logic flip, input logic [1:0] st,
                       output logic [15:0] b, output int n);
    int nd, pm, ns;
    logic p;
    cfg(k, nd, pm, ns);
    b = '1;
    n = 0;
    b[n] = 1'b0; n++;
    for (int i = 0; i < nd; i++) begin b[n] = d[i]; n++; end
    if (pm != 0) begin
      p = 1'b0;
      for (int i = 0; i < nd; i++) p = p ^ d[i];
      if (pm == 1) p = ~p;
      b[n] = p ^ flip; n++;
    end
    for (int i = 0; i < ns; i++) begin b[n] = st[i]; n++; end
  endtask

  task automatic send_bits(input int k, input logic [15:0] b, input int from, input int n);
    for (int i = from; i < n; i++) begin
      rx[k] = b[i];
      cycles(BIT);
    end
    rx[k] = 1'b1;
  endtask

  task automatic wait_drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 8 * BIT) begin cycles(1); t++; end
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic wait_busy(input int k, input logic v, input int limit, output logic got);
    int t;
    t = 0;
    while (bsy[k] !== v && t < limit) begin cycles(1); t++; end
    got = bsy[k];
  endtask

  // Scoreboard side: compares each accepted word and tracks valid/overrun activity.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) begin vprev[k] = 1'b0; orun[k] = 0; end
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (val[k] && !vprev[k]) vrise[k]++;
          vprev[k] = val[k];
          if (ovr[k]) begin
            if (orun[k] == 0) ovr_cnt[k]++;
            orun[k]++;
            if (orun[k] > omax) omax = orun[k];
          end else begin
            orun[k] = 0;
          end
          if (val[k] && rdy[k]) begin
            chk("word_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("word_inst", k, e.inst);
              chk("word_data", dut_data(k), e.data);
              chk("word_perr", perr[k], e.perr);
              chk("word_ferr", ferr[k], e.ferr);
            end
          end
        end
      end
    end
  endtask

  initial begin
    logic [15:0] b;
    int          n, vr, oc;
    logic        got;
    vec_t        v;

    n_checks = 0;
    n_errs   = 0;
    omax     = 0;
    rst_n    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rx[k] = 1'b1; rdy[k] = 1'b1; vrise[k] = 0; ovr_cnt[k] = 0; orun[k] = 0; vprev[k] = 1'b0;
    end
    fork monitor(); join_none

    tbl.push_back('{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0});
    tbl.push_back('{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0});
    tbl.push_back('{0, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0});
    tbl.push_back('{0, 9'h055, 1'b0, 2'b10, 9'h055, 1'b0, 1'b1});
    tbl.push_back('{1, 9'h041, 1'b1, 2'b11, 9'h041, 1'b1, 1'b0});
    tbl.push_back('{1, 9'h041, 1'b0, 2'b11, 9'h041, 1'b0, 1'b0});
    tbl.push_back('{1, 9'h07F, 1'b0, 2'b11, 9'h07F, 1'b0, 1'b0});
    tbl.push_back('{1, 9'h02A, 1'b1, 2'b10, 9'h02A, 1'b1, 1'b1});
    tbl.push_back('{2, 9'h096, 1'b0, 2'b11, 9'h096, 1'b0, 1'b0});
    tbl.push_back('{2, 9'h096, 1'b0, 2'b01, 9'h096, 1'b0, 1'b1});
    tbl.push_back('{2, 9'h0C3, 1'b0, 2'b10, 9'h0C3, 1'b0, 1'b1});
    tbl.push_back('{3, 9'h041, 1'b0, 2'b11, 9'h041, 1'b0, 1'b0});
    tbl.push_back('{3, 9'h041, 1'b1, 2'b11, 9'h041, 1'b1, 1'b0});
    tbl.push_back('{3, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0});

    // Reset values.
    cycles(5);
    chk("rst_data", dut_data(0), 0);
    chk("rst_valid", val[0], 0);
    chk("rst_perr", perr[0], 0);
    chk("rst_ferr", ferr[0], 0);
    chk("rst_overrun", ovr[0], 0);
    chk("rst_busy", bsy[0], 0);
    rst_n = 1'b1;
    cycles(BIT);

    // 8N1 0xA5 with consumer stalled: start-detect latency and valid hold.
    rdy[0] = 1'b0;
    exp_q.push_back('{0, 9'h0A5, 1'b0, 1'b0});
    build(0, 9'h0A5, 1'b0, 2'b11, b, n);
    rx[0] = 1'b0;
    cycles(1);
    chk("start_sync_delay", bsy[0], 0);
    cycles(3);
    chk("start_detect", bsy[0], 1);
    cycles(BIT - 4);
    send_bits(0, b, 1, n);
    cycles(2 * BIT);
    chk("hold_valid", val[0], 1);
    chk("hold_data", dut_data(0), 9'h0A5);
    chk("hold_perr", perr[0], 0);
    chk("hold_ferr", ferr[0], 0);
    chk("hold_busy", bsy[0], 0);
    rdy[0] = 1'b1;
    wait_drain("hold_accept");
    cycles(1);
    chk("valid_cleared", val[0], 0);

    // Short low glitch on an idle line: false start, nothing delivered.
    vr = vrise[0];
    rx[0] = 1'b0;
    cycles(3);
    rx[0] = 1'b1;
    wait_busy(0, 1'b1, 10, got);
    chk("glitch_busy_rise", got, 1);
    wait_busy(0, 1'b0, 2 * BIT, got);
    chk("glitch_busy_fall", got, 0);
    cycles(BIT);
    chk("glitch_no_word", vrise[0], vr);

    // Break: whole frame low, delivered as 0 with frame error, no re-arm while low.
    exp_q.push_back('{0, 9'h000, 1'b0, 1'b1});
    rx[0] = 1'b0;
    cycles(10 * BIT);
    wait_drain("break_word");
    cycles(3 * BIT);
    chk("break_stays_idle", bsy[0], 0);
    rx[0] = 1'b1;
    cycles(2 * BIT);

    // Table of single frames across all configurations.
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      exp_q.push_back('{v.inst, v.exp_data, v.exp_perr, v.exp_ferr});
      build(v.inst, v.data, v.flip, v.stops, b, n);
      send_bits(v.inst, b, 0, n);
      cycles(BIT);
      wait_drain("vec_drain");
    end

    // Back-to-back frames with consumer stalled: one overrun pulse, newest word kept.
    rdy[0] = 1'b0;
    oc   = ovr_cnt[0];
    omax = 0;
    exp_q.push_back('{0, 9'h022, 1'b0, 1'b0});
    build(0, 9'h011, 1'b0, 2'b11, b, n);
    send_bits(0, b, 0, n);
    build(0, 9'h022, 1'b0, 2'b11, b, n);
    send_bits(0, b, 0, n);
    cycles(BIT);
    chk("overrun_count", ovr_cnt[0] - oc, 1);
    chk("overrun_width", omax, 1);
    chk("overrun_valid", val[0], 1);
    chk("overrun_data", dut_data(0), 9'h022);
    rdy[0] = 1'b1;
    wait_drain("overrun_accept");

    // Reset in the middle of a data bit abandons the frame.
    vr = vrise[0];
    build(0, 9'h033, 1'b0, 2'b11, b, n);
    send_bits(0, b, 0, 4);
    rx[0] = b[4];
    cycles(BIT / 2);
    rst_n = 1'b0;
    cycles(3);
    rx[0] = 1'b1;
    rst_n = 1'b1;
    cycles(2 * BIT);
    chk("reset_abort_busy", bsy[0], 0);
    chk("reset_abort_valid", val[0], 0);
    chk("reset_abort_no_word", vrise[0], vr);
    exp_q.push_back('{0, 9'h05A, 1'b0, 1'b0});
    build(0, 9'h05A, 1'b0, 2'b11, b, n);
    send_bits(0, b, 0, n);
    cycles(BIT);
    wait_drain("after_reset_word");

    cycles(BIT);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
